alu_md: RTL and testbench

- Parametrised successor to the single-cycle datapath ALU.
- Keeps the combinational integer operations, generalised to width W.
- Adds an iterative-latency multiply/divide unit with HI/LO registers and a busy handshake, so the pipeline can stall on MFHI/MFLO and on a new MD op.
- Sits in the EX stage; C feeds the EX/MEM register; hi/lo feed the MFHI/MFLO result mux.

---
 rtl/alu_md.sv | 148 ++++++++++++++
 tb/tb_alu_md.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_md.sv
// EX-stage ALU with combinational result C plus an iterative-latency MULT/DIV unit and HI/LO.
// Divider and DIV/DIVU ops are built only when ALU_MD_DIV_EN is defined.
module alu_md #(
   parameter int W           = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   input  logic [3:0]   Op,
   output logic [W-1:0] C,
   input  logic         md_start,
   input  logic [2:0]   md_op,
   output logic         busy,
   output logic [W-1:0] hi,
   output logic [W-1:0] lo
);

   localparam int SW = $clog2(W);
`ifdef ALU_MD_DIV_EN
   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
`else
   localparam int MAXC = MULT_CYCLES;
`endif
   localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [2*W-1:0]   pend_q, pend_d;
   logic             pend_wr_q, pend_wr_d;
   logic [W-1:0]     hi_q, hi_d, lo_q, lo_d;
   logic [SW-1:0]    sh;
   logic [2*W-1:0]   prod_s, prod_u;

   assign sh = A[SW-1:0];

   always_comb begin
      C = '1;
      case (Op)
         4'b0000: C = A + B;
         4'b0001: C = A - B;
         4'b0010: C = A & B;
         4'b0011: C = A | B;
         4'b0100: C = A ^ B;
         4'b0101: C = ~(A | B);
         4'b1000: C = B << sh;
         4'b1001: C = B >> sh;
         4'b1010: C = $signed(B) >>> sh;
         4'b1100: C = {{(W-1){1'b0}}, $signed(A) < $signed(B)};
         4'b1101: C = {{(W-1){1'b0}}, A < B};
         default: C = '1;
      endcase
   end

   assign prod_s = $signed({{W{A[W-1]}}, A}) * $signed({{W{B[W-1]}}, B});
   assign prod_u = {{W{1'b0}}, A} * {{W{1'b0}}, B};

`ifdef ALU_MD_DIV_EN
   logic         div_ovf;
   logic [W-1:0] div_bs, div_bu, quot_s, rem_s, quot_u, rem_u;

   // Zero divisor and MIN/-1 are steered to a divide-by-one; the zero case is then
   // suppressed at commit, and MIN/1 already yields the required overflow result.
   assign div_ovf = (A == {1'b1, {(W-1){1'b0}}}) && (B == '1);
   assign div_bs  = ((B == '0) || div_ovf) ? {{(W-1){1'b0}}, 1'b1} : B;
   assign div_bu  = (B == '0) ? {{(W-1){1'b0}}, 1'b1} : B;
   assign quot_s  = $signed(A) / $signed(div_bs);
   assign rem_s   = $signed(A) % $signed(div_bs);
   assign quot_u  = A / div_bu;
   assign rem_u   = A % div_bu;
`else
   logic unused_div_cycles;
   assign unused_div_cycles = ^DIV_CYCLES;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pend_d    = pend_q;
      pend_wr_d = pend_wr_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      case (state_q)
         S_IDLE: begin
            if (md_start) begin
               case (md_op)
                  3'b000: begin
                     pend_d = prod_s; pend_wr_d = 1'b1;
                     cnt_d = CW'(MULT_CYCLES - 1); state_d = S_BUSY;
                  end
                  3'b001: begin
                     pend_d = prod_u; pend_wr_d = 1'b1;
                     cnt_d = CW'(MULT_CYCLES - 1); state_d = S_BUSY;
                  end
`ifdef ALU_MD_DIV_EN
                  3'b010: begin
                     pend_d = {rem_s, quot_s}; pend_wr_d = (B != '0);
                     cnt_d = CW'(DIV_CYCLES - 1); state_d = S_BUSY;
                  end
                  3'b011: begin
                     pend_d = {rem_u, quot_u}; pend_wr_d = (B != '0);
                     cnt_d = CW'(DIV_CYCLES - 1); state_d = S_BUSY;
                  end
`endif
                  3'b100:  hi_d = A;
                  3'b101:  lo_d = A;
                  default: ;
               endcase
            end
         end
         S_BUSY: begin
            if (cnt_q == '0) begin
               state_d = S_IDLE;
               if (pend_wr_q) {hi_d, lo_d} = pend_q;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         pend_q    <= '0;
         pend_wr_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pend_q    <= pend_d;
         pend_wr_q <= pend_wr_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign busy = (state_q == S_BUSY);
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_alu_md.sv
// Bench for alu_md: table and random checks of C, and MULT/DIV/MTHI/MTLO sequences
// checked against an arithmetic reference model with an expected queue.
module tb_alu_md;
   localparam int W  = 32;
   localparam int MC = 5;
   localparam int DC = 10;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [W-1:0]  A, B, C, hi, lo;
   logic [3:0]    Op;
   logic          md_start, busy;
   logic [2:0]    md_op;

   int            checks = 0;
   int            failures = 0;
   logic [63:0]   exp_q[$];
   logic [31:0]   m_hi = '0, m_lo = '0;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a, b, c;
   } cvec_t;
   cvec_t tbl[9];

   alu_md #(.W(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .rst_n(rst_n), .A(A), .B(B), .Op(Op), .C(C),
      .md_start(md_start), .md_op(md_op), .busy(busy), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int                 sh = int'(a[4:0]);
      logic signed [31:0] sb = b;
      longint             sa_l = longint'($signed(a));
      longint             sb_l = longint'($signed(b));
      case (op)
         4'b0000: return a + b;
         4'b0001: return a - b;
         4'b0010: return a & b;
         4'b0011: return a | b;
         4'b0100: return a ^ b;
         4'b0101: return ~(a | b);
         4'b1000: return b << sh;
         4'b1001: return b >> sh;
         4'b1010: return sb >>> sh;
         4'b1100: return (sa_l < sb_l) ? 32'd1 : 32'd0;
         4'b1101: return (a < b) ? 32'd1 : 32'd0;
         default: return 32'hFFFF_FFFF;
      endcase
   endfunction

   function automatic int md_cycles(input logic [2:0] op);
      case (op)
         3'b000, 3'b001: return MC;
`ifdef ALU_MD_DIV_EN
         3'b010, 3'b011: return DC;
`endif
         default: return 0;
      endcase
   endfunction

   // Final {hi,lo} given the current register contents.
   function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] ch, input logic [31:0] cl);
      longint      sa = longint'($signed(a));
      longint      sb = longint'($signed(b));
      logic [63:0] ua = {32'b0, a};
      logic [63:0] ub = {32'b0, b};
      logic [63:0] q, r;
      case (op)
         3'b000: return sa * sb;
         3'b001: return ua * ub;
`ifdef ALU_MD_DIV_EN
         3'b010: begin
            if (b == 0) return {ch, cl};
            q = sa / sb; r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         3'b011: begin
            if (b == 0) return {ch, cl};
            q = ua / ub; r = ua % ub;
            return {r[31:0], q[31:0]};
         end
`endif
         3'b100: return {a, cl};
         3'b101: return {ch, a};
         default: return {ch, cl};
      endcase
   endfunction

   // Caller is at a negedge; returns at the negedge where busy is observed low.
   task automatic md_run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string name);
      int          cyc = 0;
      logic [63:0] e;
      exp_q.push_back(ref_md(op, a, b, m_hi, m_lo));
      md_op = op; A = a; B = b; md_start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      md_start = 1'b0; A = $urandom; B = $urandom;
      while (busy === 1'b1 && cyc < 100) begin
         check({name, "_hold"}, {hi, lo}, {m_hi, m_lo});
         cyc++;
         @(negedge clk);
      end
      check({name, "_cycles"}, 64'(cyc), 64'(md_cycles(op)));
      e = exp_q.pop_front();
      check({name, "_hilo"}, {hi, lo}, e);
      {m_hi, m_lo} = e;
   endtask

   initial begin
      int          cyc;
      logic [2:0]  rop;
      logic [31:0] ra, rb;

      rst_n = 1'b0; A = '0; B = '0; Op = '0; md_start = 1'b0; md_op = '0;
      tbl[0] = '{4'b1100, 32'd5, 32'hFFFF_FFFF, 32'd0};
      tbl[1] = '{4'b1101, 32'd5, 32'hFFFF_FFFF, 32'd1};
      tbl[2] = '{4'b1010, 32'd4, 32'h8000_0000, 32'hF800_0000};
      tbl[3] = '{4'b0111, 32'd4, 32'h8000_0000, 32'hFFFF_FFFF};
      tbl[4] = '{4'b0000, 32'hFFFF_FFFF, 32'd1, 32'd0};
      tbl[5] = '{4'b0001, 32'd0, 32'd1, 32'hFFFF_FFFF};
      tbl[6] = '{4'b0101, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0000_0F0F};
      tbl[7] = '{4'b1000, 32'd31, 32'd1, 32'h8000_0000};
      tbl[8] = '{4'b1001, 32'h24, 32'h8000_0000, 32'h0800_0000};

      #12;
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_hilo", {hi, lo}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         Op = tbl[i].op; A = tbl[i].a; B = tbl[i].b;
         #1;
         check($sformatf("comb_tbl%0d", i), 64'(C), 64'(tbl[i].c));
      end
      for (int i = 0; i < 200; i++) begin
         Op = 4'($urandom_range(0, 15)); A = $urandom; B = $urandom;
         #1;
         check($sformatf("comb_rnd_op%0h", Op), 64'(C), 64'(ref_alu(Op, A, B)));
      end

      @(negedge clk);
      md_run(3'b000, 32'hFFFF_FFFD, 32'd7, "mult");
      check("mult_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
      md_run(3'b001, 32'hFFFF_FFFD, 32'd7, "multu");
      check("multu_const", {hi, lo}, 64'h0000_0006_FFFF_FFEB);
      md_run(3'b100, 32'hAB, 32'd0, "mthi");
      check("mthi_const", 64'(hi), 64'hAB);
      @(negedge clk);
      check("mthi_busy_idle", 64'(busy), 64'd0);

      // MTLO attempted while a MULT is in flight must be dropped.
      md_op = 3'b000; A = 32'hFFFF_FFFD; B = 32'd7; md_start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      md_op = 3'b101; A = 32'h55; md_start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      md_start = 1'b0;
      cyc = 1;
      while (busy === 1'b1 && cyc < 100) begin cyc++; @(negedge clk); end
      check("mtlo_busy_cycles", 64'(cyc), 64'(MC));
      check("mtlo_busy_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
      {m_hi, m_lo} = {hi, lo};
      if (lo === 32'hFFFF_FFEB) {m_hi, m_lo} = 64'hFFFF_FFFF_FFFF_FFEB;

`ifdef ALU_MD_DIV_EN
      md_run(3'b010, 32'hFFFF_FFF9, 32'd2, "div");
      check("div_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      md_run(3'b100, 32'h11, 32'd0, "mthi11");
      md_run(3'b101, 32'h22, 32'd0, "mtlo22");
      md_run(3'b011, 32'd7, 32'd0, "divu_zero");
      check("divu_zero_const", {hi, lo}, 64'h0000_0011_0000_0022);
      md_run(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
      check("div_ovf_const", {hi, lo}, 64'h0000_0000_8000_0000);
`else
      md_run(3'b010, 32'hFFFF_FFF9, 32'd2, "div_reserved");
      md_run(3'b011, 32'd7, 32'd3, "divu_reserved");
`endif
      md_run(3'b110, 32'h1234, 32'd1, "rsv110");
      md_run(3'b111, 32'h5678, 32'd1, "rsv111");

      for (int i = 0; i < 30; i++) begin
         rop = 3'($urandom_range(0, 5));
         ra = $urandom;
         rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 9)) - 32'd5;
         md_run(rop, ra, rb, $sformatf("md_rnd_op%0d", rop));
      end

      md_run(3'b101, 32'hCAFE, 32'd0, "mtlo_pre_rst");
      md_op = 3'b000; A = 32'hFFFF_FFFD; B = 32'd7; md_start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      md_start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_busy", 64'(busy), 64'd0);
      check("rst_mid_hilo", {hi, lo}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      check("rst_after_busy", 64'(busy), 64'd0);
      check("rst_after_hilo", {hi, lo}, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
